// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU front-end definitions: opcode and select encodings plus the opcode->select decode.
package alu_share_arbiter_pkg;

  typedef logic [2:0] alu_op_t;
  typedef logic [4:0] alu_sel_t;

  localparam alu_op_t OP_ADD = 3'd0;
  localparam alu_op_t OP_SUB = 3'd1;
  localparam alu_op_t OP_SEQ = 3'd2;
  localparam alu_op_t OP_SNE = 3'd3;
  localparam alu_op_t OP_SLT = 3'd4;
  localparam alu_op_t OP_SGT = 3'd5;
  localparam alu_op_t OP_SLE = 3'd6;
  localparam alu_op_t OP_SGE = 3'd7;

  // {sel4,sel3,sel2,sel1,sel0}; don't-care bits are held at 0.
  localparam alu_sel_t SEL_ADD = 5'b00000;
  localparam alu_sel_t SEL_SUB = 5'b11000;
  localparam alu_sel_t SEL_SEQ = 5'b10000;
  localparam alu_sel_t SEL_SNE = 5'b10001;
  localparam alu_sel_t SEL_SLT = 5'b10010;
  localparam alu_sel_t SEL_SGT = 5'b10011;
  localparam alu_sel_t SEL_SLE = 5'b10100;
  localparam alu_sel_t SEL_SGE = 5'b10110;

  function automatic alu_sel_t alu_decode(input alu_op_t op);
    alu_sel_t sel;
    unique case (op)
      OP_ADD:  sel = SEL_ADD;
      OP_SUB:  sel = SEL_SUB;
      OP_SEQ:  sel = SEL_SEQ;
      OP_SNE:  sel = SEL_SNE;
      OP_SLT:  sel = SEL_SLT;
      OP_SGT:  sel = SEL_SGT;
      OP_SLE:  sel = SEL_SLE;
      OP_SGE:  sel = SEL_SGE;
      default: sel = SEL_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i wins (one-hot + index).
module alu_rr_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // Scan offsets from the pointer; constant j keeps every select index static.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!any_o && (((int'(ptr_i) + int'(k)) % int'(N_REQ)) == int'(j)) && req_i[j]) begin
          gnt_o[j] = 1'b1;
          idx_o    = ID_W'(j);
          any_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between N_REQ requesters with a 1-entry tagged response register.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no round-robin pointer).
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [3*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [31:0]           alu_in1,
  output logic [31:0]           alu_in2,
  output logic [4:0]            alu_sel,
  input  logic [31:0]           alu_out,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  busy
);

  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;

  logic             can_issue;
  logic [N_REQ-1:0] pick_req;
  logic [N_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [ID_W-1:0]  pick_ptr;

  // Reset also masks requests so req_ready stays low while reset_n is asserted.
  assign can_issue = !resp_valid_q || resp_ready;
  assign pick_req  = req_valid & {N_REQ{can_issue && reset_n}};

  alu_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_i (pick_req),
    .ptr_i (pick_ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pick_any) begin
      rr_ptr_d = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign pick_ptr = rr_ptr_q;
`endif

  // One-hot AND-OR mux onto the ALU; all zero when nothing is granted.
  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    alu_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        alu_in1 = alu_in1 | req_a[32*i +: 32];
        alu_in2 = alu_in2 | req_b[32*i +: 32];
        alu_sel = alu_sel | alu_decode(req_op[3*i +: 3]);
      end
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    if (pick_any) begin
      resp_valid_d = 1'b1;
      resp_data_d  = alu_out;
      resp_id_d    = pick_idx;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign req_ready  = pick_gnt;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = resp_valid_q || (|req_valid);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU driven from alu_sel.
module tb_alu_share_arbiter;

  localparam int unsigned N = 2;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [31:0]     alu_in1, alu_in2, alu_out;
  logic [4:0]      alu_sel;
  logic            resp_valid, resp_ready, busy;
  logic [31:0]     resp_data;
  logic [IW-1:0]   resp_id;

  int checks = 0;
  int failures = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  // Behavioural ALU keyed on the select vector.
  function automatic logic [31:0] alu_model(input logic [4:0] s, input logic [31:0] x,
                                            input logic [31:0] y);
    case (s)
      5'b00000: return x + y;
      5'b11000: return x - y;
      5'b10000: return {31'd0, x == y};
      5'b10001: return {31'd0, x != y};
      5'b10010: return {31'd0, $signed(x) <  $signed(y)};
      5'b10011: return {31'd0, $signed(x) >  $signed(y)};
      5'b10100: return {31'd0, $signed(x) <= $signed(y)};
      5'b10110: return {31'd0, $signed(x) >= $signed(y)};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_out = alu_model(alu_sel, alu_in1, alu_in2);

  typedef struct {
    int unsigned id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sel;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int unsigned id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid[id]       = 1'b1;
    req_op[3*id +: 3]   = op;
    req_a[32*id +: 32]  = a;
    req_b[32*id +: 32]  = b;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  logic [N-1:0] exp_gnt;
  int           w;
  logic [31:0]  held_data;
  logic [IW-1:0] held_id;

  initial begin
    vecs[0] = '{0, 3'd0, 32'd5,          32'd7,          5'b00000, 32'd12};
    vecs[1] = '{1, 3'd4, 32'd3,          32'd9,          5'b10010, 32'd1};
    vecs[2] = '{1, 3'd7, 32'd3,          32'd9,          5'b10110, 32'd0};
    vecs[3] = '{0, 3'd1, 32'd0,          32'd1,          5'b11000, 32'hFFFF_FFFF};
    vecs[4] = '{1, 3'd2, 32'h8000_0000,  32'h8000_0000,  5'b10000, 32'd1};
    vecs[5] = '{0, 3'd3, 32'd1,          32'd2,          5'b10001, 32'd1};
    vecs[6] = '{1, 3'd5, 32'd9,          32'd3,          5'b10011, 32'd1};
    vecs[7] = '{0, 3'd6, 32'd4,          32'd4,          5'b10100, 32'd1};

    reset_n = 1'b0;
    resp_ready = 1'b1;
    clr_req();
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    set_req(0, 3'd0, 32'd1, 32'd1);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    clr_req();
    @(negedge clk);
    reset_n = 1'b1;

    // Single-requester vectors, back to back with resp_ready high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clr_req();
      set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      exp_gnt = '0;
      exp_gnt[vecs[i].id] = 1'b1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(exp_gnt));
      chk($sformatf("v%0d_alu_sel", i), 32'(alu_sel), 32'(vecs[i].sel));
      chk($sformatf("v%0d_alu_in1", i), alu_in1, vecs[i].a);
      chk($sformatf("v%0d_alu_in2", i), alu_in2, vecs[i].b);
      @(posedge clk);
      #1;
      exp_ptr = (vecs[i].id + 1) % N;
      chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d_resp_data", i), resp_data, vecs[i].data);
      chk($sformatf("v%0d_resp_id", i), 32'(resp_id), vecs[i].id);
    end

    // Idle: ALU inputs zeroed, response drains.
    @(negedge clk);
    clr_req();
    #1;
    chk("idle_alu_sel", 32'(alu_sel), 32'd0);
    chk("idle_alu_in1", alu_in1, 32'd0);
    chk("idle_alu_in2", alu_in2, 32'd0);
    chk("idle_busy_pending", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Both requesting every cycle.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_req(0, 3'd0, 32'd1, 32'd1);
      set_req(1, 3'd0, 32'd10, 32'd10);
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = exp_ptr;
`endif
      #1;
      exp_gnt = '0;
      exp_gnt[w] = 1'b1;
      chk($sformatf("rr%0d_req_ready", c), 32'(req_ready), 32'(exp_gnt));
      @(posedge clk);
      #1;
      exp_ptr = (w + 1) % N;
      chk($sformatf("rr%0d_resp_id", c), 32'(resp_id), 32'(w));
      chk($sformatf("rr%0d_resp_data", c), resp_data, (w == 0) ? 32'd2 : 32'd20);
    end
    held_data = (w == 0) ? 32'd2 : 32'd20;
    held_id   = IW'(w);

    // Backpressure for three cycles, then release.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_alu_sel", c), 32'(alu_sel), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_resp_valid", c), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d_resp_data", c), resp_data, held_data);
      chk($sformatf("bp%0d_resp_id", c), 32'(resp_id), 32'(held_id));
    end
    @(negedge clk);
    resp_ready = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    w = 0;
`else
    w = exp_ptr;
`endif
    #1;
    exp_gnt = '0;
    exp_gnt[w] = 1'b1;
    chk("bp_release_req_ready", 32'(req_ready), 32'(exp_gnt));
    @(posedge clk);
    #1;
    chk("bp_release_resp_id", 32'(resp_id), 32'(w));
    chk("bp_release_resp_valid", 32'(resp_valid), 32'd1);

    // Reset mid-traffic with a result held.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_resp_data", resp_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    exp_gnt = 2'b01;
    chk("postrst_req_ready", 32'(req_ready), 32'(exp_gnt));
    @(posedge clk);
    #1;
    chk("postrst_resp_id", 32'(resp_id), 32'd0);
    chk("postrst_resp_data", resp_data, 32'd2);
    @(negedge clk);
    clr_req();
    @(posedge clk);
    #1;
    chk("final_resp_valid", 32'(resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
